// File: rtl/c7b_exc_pkg.sv
// Shared types and constants for the c7b exception entry controller.
// C7B_SWI_EN makes LIE[1:0] writable and lets ESTAT.SIS raise interrupts.
package c7b_exc_pkg;

    localparam int LIE_W = 13;
    localparam logic [5:0] ECODE_INT = 6'd0;
    localparam logic [13:0] LCSR_ECFG = 14'h4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_FLUSH,
        ST_HOLD
    } exc_state_t;

    typedef enum logic [1:0] {
        EV_EXC,
        EV_INT,
        EV_ERTN
    } exc_kind_t;

    // LIE[12] is reserved in every build.
`ifdef C7B_SWI_EN
    localparam logic [LIE_W-1:0] LIE_WR_MASK = 13'h0FFF;
`else
    localparam logic [LIE_W-1:0] LIE_WR_MASK = 13'h0FFC;
`endif

    function automatic logic [LIE_W-1:0] lie_update(input logic [LIE_W-1:0] old,
                                                    input logic [LIE_W-1:0] wdata,
                                                    input logic [LIE_W-1:0] mask);
        logic [LIE_W-1:0] m;
        m = mask & LIE_WR_MASK;
        return (old & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/c7bexc_holdoff.sv
// Loadable down-counter with a zero flag, used to keep interrupts
// suppressed for a few retired instructions after an ERTN.
module c7bexc_holdoff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/c7bexc_ctl.sv
// Exception/interrupt entry controller: picks one event at _w, pulses the CSR
// commit, then holds the front end in a flush handshake. Optional: C7B_SWI_EN.
module c7bexc_ctl
    import c7b_exc_pkg::*;
#(
    parameter int HOLDOFF_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecl_inst_valid_w,
    input  logic        ecl_exc_valid_w,
    input  logic [5:0]  ecl_exc_code_w,
    input  logic [31:0] ecl_exc_badv_w,
    input  logic [31:0] ecl_pc_w,
    input  logic        ecl_ertn_w,
    input  logic        csr_crmd_ie,
    input  logic [12:0] csr_estat_is,
    input  logic [1:0]  csr_estat_sis,
    input  logic        csr_wen,
    input  logic [13:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] csr_mask,
    output logic [12:0] ecfg_lie,
    output logic        exu_ifu_except,
    output logic [5:0]  ecl_csr_exccode_w,
    output logic [31:0] ecl_csr_badv_w,
    output logic [31:0] ifu_exu_pc_w,
    output logic        ecl_csr_ertn_w,
    output logic        exc_stall,
    output logic        ifu_flush_req,
    input  logic        ifu_flush_ack
);

    exc_state_t state;
    exc_kind_t  kind;
    logic [LIE_W-1:0] is_eff;
    logic hold_zero;
    logic int_pend;
    logic accept;
    logic take_int;
    logic take_exc;
    logic take_ertn;
    logic hold_load;
    logic unused_bits;

`ifdef C7B_SWI_EN
    assign is_eff = {csr_estat_is[12:2], csr_estat_sis};
`else
    assign is_eff = {csr_estat_is[12:2], 2'b00};
`endif

    assign unused_bits = ^{csr_wdata[31:13], csr_mask[31:13], csr_estat_is[1:0], csr_estat_sis};

    always_ff @(posedge clk) begin
        if (rst) begin
            ecfg_lie <= '0;
        end else if (csr_wen && csr_waddr == LCSR_ECFG) begin
            ecfg_lie <= lie_update(ecfg_lie, csr_wdata[LIE_W-1:0], csr_mask[LIE_W-1:0]);
        end
    end

    // The holdoff counter is only nonzero after an ERTN, so it masks interrupts in HOLD.
    assign int_pend  = csr_crmd_ie & (|(is_eff & ecfg_lie)) & hold_zero;
    assign accept    = (state == ST_IDLE) || (state == ST_HOLD);
    assign take_int  = accept & ecl_inst_valid_w & int_pend & ~ecl_ertn_w;
    assign take_exc  = accept & ~take_int & ecl_exc_valid_w;
    assign take_ertn = accept & ~take_int & ~ecl_exc_valid_w & ecl_ertn_w;
    assign hold_load = (state == ST_FLUSH) & ifu_flush_ack & (kind == EV_ERTN);

    c7bexc_holdoff #(.W(4)) u_holdoff (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (4'(HOLDOFF_CYC)),
        .dec      (ecl_inst_valid_w),
        .zero     (hold_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            kind              <= EV_EXC;
            exu_ifu_except    <= 1'b0;
            ecl_csr_ertn_w    <= 1'b0;
            ecl_csr_exccode_w <= '0;
            ecl_csr_badv_w    <= '0;
            ifu_exu_pc_w      <= '0;
            exc_stall         <= 1'b0;
            ifu_flush_req     <= 1'b0;
        end else begin
            exu_ifu_except <= take_int | take_exc;
            ecl_csr_ertn_w <= take_ertn;
            unique case (state)
                ST_IDLE, ST_HOLD: begin
                    if (take_int) begin
                        kind              <= EV_INT;
                        ecl_csr_exccode_w <= ECODE_INT;
                        ecl_csr_badv_w    <= '0;
                        ifu_exu_pc_w      <= ecl_pc_w;
                    end else if (take_exc) begin
                        kind              <= EV_EXC;
                        ecl_csr_exccode_w <= ecl_exc_code_w;
                        ecl_csr_badv_w    <= ecl_exc_badv_w;
                        ifu_exu_pc_w      <= ecl_pc_w;
                    end else if (take_ertn) begin
                        kind              <= EV_ERTN;
                        ecl_csr_exccode_w <= '0;
                        ecl_csr_badv_w    <= '0;
                        ifu_exu_pc_w      <= ecl_pc_w;
                    end
                    if (take_int || take_exc || take_ertn) begin
                        state     <= ST_COMMIT;
                        exc_stall <= 1'b1;
                    end else if (state == ST_HOLD && hold_zero) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    state         <= ST_FLUSH;
                    ifu_flush_req <= 1'b1;
                end
                ST_FLUSH: begin
                    if (ifu_flush_ack) begin
                        ifu_flush_req <= 1'b0;
                        exc_stall     <= 1'b0;
                        state <= (kind == EV_ERTN && HOLDOFF_CYC != 0) ? ST_HOLD : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c7bexc_ctl.sv
// Scoreboard bench for c7bexc_ctl: expected commits are queued when events are
// driven and popped when the DUT pulses; optionally built with C7B_SWI_EN.
module tb_c7bexc_ctl;
    import c7b_exc_pkg::*;

    localparam int HOLDOFF = 4;
`ifdef C7B_SWI_EN
    localparam bit SWI = 1'b1;
`else
    localparam bit SWI = 1'b0;
`endif

    typedef struct packed {
        logic        exc;
        logic        ertn;
        logic [5:0]  code;
        logic [31:0] badv;
        logic [31:0] pc;
    } commit_t;

    logic clk = 1'b0;
    logic rst;
    logic ecl_inst_valid_w, ecl_exc_valid_w, ecl_ertn_w;
    logic [5:0] ecl_exc_code_w;
    logic [31:0] ecl_exc_badv_w, ecl_pc_w;
    logic csr_crmd_ie;
    logic [12:0] csr_estat_is;
    logic [1:0] csr_estat_sis;
    logic csr_wen;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata, csr_mask;
    logic [12:0] ecfg_lie;
    logic exu_ifu_except, ecl_csr_ertn_w, exc_stall, ifu_flush_req, ifu_flush_ack;
    logic [5:0] ecl_csr_exccode_w;
    logic [31:0] ecl_csr_badv_w, ifu_exu_pc_w;

    commit_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int pushed = 0;

    c7bexc_ctl #(.HOLDOFF_CYC(HOLDOFF)) dut (
        .clk(clk), .rst(rst),
        .ecl_inst_valid_w(ecl_inst_valid_w), .ecl_exc_valid_w(ecl_exc_valid_w),
        .ecl_exc_code_w(ecl_exc_code_w), .ecl_exc_badv_w(ecl_exc_badv_w),
        .ecl_pc_w(ecl_pc_w), .ecl_ertn_w(ecl_ertn_w),
        .csr_crmd_ie(csr_crmd_ie), .csr_estat_is(csr_estat_is), .csr_estat_sis(csr_estat_sis),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_mask(csr_mask),
        .ecfg_lie(ecfg_lie), .exu_ifu_except(exu_ifu_except),
        .ecl_csr_exccode_w(ecl_csr_exccode_w), .ecl_csr_badv_w(ecl_csr_badv_w),
        .ifu_exu_pc_w(ifu_exu_pc_w), .ecl_csr_ertn_w(ecl_csr_ertn_w),
        .exc_stall(exc_stall), .ifu_flush_req(ifu_flush_req), .ifu_flush_ack(ifu_flush_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops one expected commit per pulse; a pulse with nothing queued is a failure.
    always @(negedge clk) begin
        if (!rst && (exu_ifu_except || ecl_csr_ertn_w)) begin
            commit_t e;
            pulses++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", {62'd0, exu_ifu_except, ecl_csr_ertn_w}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pulse_kind", {62'd0, exu_ifu_except, ecl_csr_ertn_w}, {62'd0, e.exc, e.ertn});
                if (e.exc) begin
                    checkOutput("ecode", 64'(ecl_csr_exccode_w), 64'(e.code));
                    checkOutput("badv", 64'(ecl_csr_badv_w), 64'(e.badv));
                    checkOutput("era", 64'(ifu_exu_pc_w), 64'(e.pc));
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectCommit(input logic exc, input logic ertn, input logic [5:0] code,
                                input logic [31:0] badv, input logic [31:0] pc);
        exp_q.push_back('{exc, ertn, code, badv, pc});
        pushed++;
    endtask

    task automatic applyStimulus(input logic valid, input logic exc, input logic [5:0] code,
                                 input logic [31:0] badv, input logic [31:0] pc, input logic ertn);
        ecl_inst_valid_w = valid;
        ecl_exc_valid_w  = exc;
        ecl_exc_code_w   = code;
        ecl_exc_badv_w   = badv;
        ecl_pc_w         = pc;
        ecl_ertn_w       = ertn;
        cycle();
        ecl_inst_valid_w = 1'b0;
        ecl_exc_valid_w  = 1'b0;
        ecl_ertn_w       = 1'b0;
    endtask

    task automatic writeCsr(input logic [13:0] addr, input logic [31:0] data, input logic [31:0] mask);
        csr_wen = 1'b1;
        csr_waddr = addr;
        csr_wdata = data;
        csr_mask = mask;
        cycle();
        csr_wen = 1'b0;
    endtask

    task automatic flushAck();
        int n = 0;
        while (ifu_flush_req !== 1'b1 && n < 8) begin
            cycle();
            n++;
        end
        checkOutput("flush_req_seen", {63'd0, ifu_flush_req}, 64'd1);
        cycle();
        checkOutput("flush_req_hold", {62'd0, ifu_flush_req, exc_stall}, 64'd3);
        ifu_flush_ack = 1'b1;
        cycle();
        ifu_flush_ack = 1'b0;
        checkOutput("flush_done", {62'd0, ifu_flush_req, exc_stall}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        ecl_inst_valid_w = 0; ecl_exc_valid_w = 0; ecl_ertn_w = 0;
        ecl_exc_code_w = 0; ecl_exc_badv_w = 0; ecl_pc_w = 0;
        csr_crmd_ie = 0; csr_estat_is = 0; csr_estat_sis = 0;
        csr_wen = 0; csr_waddr = 0; csr_wdata = 0; csr_mask = 0;
        ifu_flush_ack = 0;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        checkOutput("reset_ctl", {59'd0, exu_ifu_except, ecl_csr_ertn_w, exc_stall, ifu_flush_req, 1'b0}, 64'd0);
        checkOutput("reset_data", {13'd0, ecfg_lie, ecl_csr_exccode_w, ecl_csr_badv_w}, 64'd0);
        checkOutput("reset_pc", 64'(ifu_exu_pc_w), 64'd0);

        writeCsr(14'h4, 32'h1FFF, 32'hFFFF_FFFF);
        checkOutput("lie_all", 64'(ecfg_lie), SWI ? 64'h0FFF : 64'h0FFC);
        writeCsr(14'h4, 32'h0, 32'h0000_0FF0);
        checkOutput("lie_masked", 64'(ecfg_lie), SWI ? 64'h000F : 64'h000C);
        writeCsr(14'h5, 32'h0, 32'hFFFF_FFFF);
        checkOutput("lie_other_addr", 64'(ecfg_lie), SWI ? 64'h000F : 64'h000C);

        // Timer-class interrupt on IS[11] so the default build can take it.
        writeCsr(14'h4, 32'h800, 32'hFFFF_FFFF);
        csr_crmd_ie = 1'b1;
        csr_estat_is = 13'h800;
        expectCommit(1, 0, 6'd0, 32'd0, 32'h1C00_0100);
        applyStimulus(1, 0, 6'd0, 32'd0, 32'h1C00_0100, 0);
        checkOutput("int_commit_n1", {62'd0, exu_ifu_except, exc_stall}, 64'd3);
        cycle();
        checkOutput("int_flush_n2", {62'd0, exu_ifu_except, ifu_flush_req}, 64'd1);
        flushAck();
        csr_crmd_ie = 1'b0;

        expectCommit(1, 0, 6'h09, 32'h3, 32'h100);
        applyStimulus(1, 1, 6'h09, 32'h3, 32'h100, 0);
        ecl_exc_valid_w = 1'b1;
        ecl_inst_valid_w = 1'b1;
        ecl_exc_code_w = 6'h0A;
        cycle();
        cycle();
        ecl_exc_valid_w = 1'b0;
        ecl_inst_valid_w = 1'b0;
        flushAck();
        repeat (3) cycle();
        checkOutput("single_pulse", 64'(pulses), 64'(pushed));

        csr_crmd_ie = 1'b1;
        expectCommit(1, 0, 6'd0, 32'd0, 32'h200);
        applyStimulus(1, 1, 6'h0C, 32'hDEAD, 32'h200, 0);
        flushAck();

        csr_wen = 1'b1; csr_waddr = 14'h4; csr_wdata = 32'h0; csr_mask = 32'hFFFF_FFFF;
        expectCommit(1, 0, 6'd0, 32'd0, 32'h240);
        applyStimulus(1, 0, 6'd0, 32'd0, 32'h240, 0);
        csr_wen = 1'b0;
        checkOutput("lie_same_cycle", {51'd0, ecfg_lie}, 64'd0);
        flushAck();

        writeCsr(14'h4, 32'h800, 32'hFFFF_FFFF);
        expectCommit(0, 1, 6'd0, 32'd0, 32'h400);
        applyStimulus(1, 0, 6'd0, 32'd0, 32'h400, 1);
        flushAck();
        for (int i = 0; i < HOLDOFF; i++) begin
            applyStimulus(1, 0, 6'd0, 32'd0, 32'h500 + 32'(i), 0);
        end
        checkOutput("hold_no_stall", {62'd0, exc_stall, exu_ifu_except}, 64'd0);
        expectCommit(1, 0, 6'd0, 32'd0, 32'h510);
        applyStimulus(1, 0, 6'd0, 32'd0, 32'h510, 0);
        checkOutput("hold_then_int", {63'd0, exu_ifu_except}, 64'd1);
        flushAck();
        csr_crmd_ie = 1'b0;

        csr_estat_is = 13'h0;
        csr_estat_sis = 2'b11;
        writeCsr(14'h4, 32'h3, 32'hFFFF_FFFF);
        checkOutput("lie_swi", 64'(ecfg_lie), SWI ? 64'h3 : 64'h0);
        csr_crmd_ie = 1'b1;
        if (SWI) expectCommit(1, 0, 6'd0, 32'd0, 32'h300);
        applyStimulus(1, 0, 6'd0, 32'd0, 32'h300, 0);
        cycle();
        checkOutput("swi_flush", {63'd0, ifu_flush_req}, {63'd0, SWI});
        csr_crmd_ie = 1'b0;
        ifu_flush_ack = 1'b1;
        cycle();
        ifu_flush_ack = 1'b0;
        cycle();

        expectCommit(1, 0, 6'h04, 32'h44, 32'h600);
        applyStimulus(1, 1, 6'h04, 32'h44, 32'h600, 0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("reset_mid_flush", {59'd0, exu_ifu_except, ecl_csr_ertn_w, exc_stall, ifu_flush_req, 1'b0}, 64'd0);
        checkOutput("reset_lie", 64'(ecfg_lie), 64'd0);
        repeat (3) cycle();
        checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("pulse_total", 64'(pulses), 64'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
